// File: rtl/pic_exec_unit.sv
// pic_exec_unit: execute stage of the 12-bit PIC core with W, C/Z, register file and PC advance requests
module pic_exec_unit #(
  parameter int PC_W  = 10,
  parameter int RF_AW = 4
) (
  input  logic            CK,
  input  logic            CLR,
  input  logic            run,
  input  logic [11:0]     instr,
  input  logic            instr_valid,
  output logic            instr_ready,
  output logic            pc_step,
  output logic [PC_W-1:0] pc_offset,
  output logic [7:0]      w_out,
  output logic [1:0]      status,
  output logic            illegal,
  output logic [1:0]      state_out
);
  typedef enum logic [1:0] {WAIT = 2'd0, EXEC = 2'd1, SKIP = 2'd2} state_t;
  state_t r_state, w_next;
  logic [11:0] r_ir;
  logic [7:0] r_w;
  logic r_c, r_z, r_pc_step, r_illegal;
  logic [PC_W-1:0] r_pc_offset;
  logic [7:0] r_rf [2**RF_AW];
  logic [3:0] w_op;
  logic [7:0] w_k, w_rf, w_nw, w_rf_d;
  logic [RF_AW-1:0] w_f;
  logic [8:0] w_sum;
  logic w_wwe, w_cwe, w_zwe, w_c, w_rf_we, w_skip, w_ill, w_step, w_accept;
  assign w_op = r_ir[11:8];
  assign w_k = r_ir[7:0];
  assign w_f = r_ir[RF_AW-1:0];
  assign w_rf = r_rf[w_f];
  assign w_sum = {1'b0, r_w} + {1'b0, w_op == 4'h2 ? w_k : w_rf};
  assign w_accept = run && r_state == WAIT && instr_valid;
  assign w_step = run && (r_state == EXEC || (r_state == SKIP && instr_valid));
  assign instr_ready = run && (r_state == WAIT || r_state == SKIP);
  assign pc_step = r_pc_step;
  assign pc_offset = r_pc_offset;
  assign w_out = r_w;
  assign status = {r_c, r_z};
  assign illegal = r_illegal;
  assign state_out = r_state;
  always_comb begin
    w_nw = r_w;
    w_wwe = 1'b0;
    w_cwe = 1'b0;
    w_zwe = 1'b0;
    w_c = r_c;
    w_rf_we = 1'b0;
    w_rf_d = r_w;
    w_skip = 1'b0;
    w_ill = 1'b0;
    case (w_op)
      4'h1: begin w_nw = w_k; w_wwe = 1'b1; end
      4'h2, 4'h8: begin w_nw = w_sum[7:0]; w_c = w_sum[8]; w_wwe = 1'b1; w_cwe = 1'b1; w_zwe = 1'b1; end
      4'h3: begin w_nw = r_w & w_k; w_wwe = 1'b1; w_zwe = 1'b1; end
      4'h4: begin w_nw = r_w | w_k; w_wwe = 1'b1; w_zwe = 1'b1; end
      4'h5: begin w_nw = r_w ^ w_k; w_wwe = 1'b1; w_zwe = 1'b1; end
      4'h6: w_rf_we = 1'b1;
      4'h7: begin w_nw = w_rf; w_wwe = 1'b1; w_zwe = 1'b1; end
      4'h9: begin w_rf_d = w_rf + 8'd1; w_rf_we = 1'b1; w_skip = w_rf_d == 8'd0; end
      4'hB: w_skip = w_rf[r_ir[6:4]];
      4'hC, 4'hD, 4'hE, 4'hF: w_ill = 1'b1;
      default: ;
    endcase
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      WAIT: w_next = w_accept ? EXEC : WAIT;
      EXEC: w_next = run ? (w_skip ? SKIP : WAIT) : EXEC;
      SKIP: w_next = (run && instr_valid) ? WAIT : SKIP;
      default: w_next = WAIT;
    endcase
  end
  always_ff @(posedge CK) begin
    if (CLR) begin
      r_state <= WAIT;
      r_ir <= 12'd0;
      r_w <= 8'd0;
      r_c <= 1'b0;
      r_z <= 1'b0;
      r_pc_step <= 1'b0;
      r_pc_offset <= '0;
      r_illegal <= 1'b0;
      for (int i = 0; i < 2**RF_AW; i++) r_rf[i] <= 8'd0;
    end else begin
      r_state <= w_next;
      r_pc_step <= w_step;
      r_illegal <= 1'b0;
      if (w_accept) r_ir <= instr;
      // BRA offset only applies to the EXEC step; a skip-discard always advances by one
      if (w_step) r_pc_offset <= (r_state == EXEC && w_op == 4'hA) ? {{(PC_W-8){w_k[7]}}, w_k} : PC_W'(1);
      if (run && r_state == EXEC) begin
        r_illegal <= w_ill;
        if (w_wwe) r_w <= w_nw;
        if (w_cwe) r_c <= w_c;
        if (w_zwe) r_z <= w_nw == 8'd0;
        if (w_rf_we) r_rf[w_f] <= w_rf_d;
      end
    end
  end
endmodule
